uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped 8N1 UART transmitter on the CPU's 12-bit address / 4-bit data bus, downstream of the CPU core alongside program/data memory. The CPU writes a byte as two nibble stores into a one-byte holding register. A serialiser shifts the byte out on `tx` at a fixed divided bit rate. A status nibble lets software poll before each store.

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per UART bit; legal range ≥ 2.
- `BASE_ADDR`, 12'hFF0: base of the 4-address window; bits [1:0] must be 0.

Ports:
- `clk`  in  1  clock; reset is synchronous, active-high (`reset`).
- `reset`  in  1  synchronous, active-high.
- `bus_addr`  in  12  CPU bus address.
- `bus_wdata`  in  4  CPU write nibble.
- `bus_we`  in  1  write strobe; `bus_wdata` is valid in a cycle where this is high.
- `bus_rdata`  out  4  read nibble; combinational from `bus_addr` and registered state.
- `bus_sel`  out  1  high when `bus_addr` is inside the window; the top level uses it to mux `bus_rdata` onto the CPU data bus.
- `tx`  out  1  serial output, idle high.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - +0 DATA_LO: write-only; stored in `lo_nib`.
  - +1 DATA_HI: write-only; launches a byte.
  - +2 STATUS: read returns {0, overrun, busy, hold_full}; a write of any value clears overrun.
  - +3 reserved: reads 0, writes ignored.
- Reads of +0 and +1 return 0.
- DATA_LO write: `lo_nib` <= `bus_wdata`. This is always accepted and does not depend on hold_full.
- DATA_HI write:
  - If hold_full=0: hold <= {`bus_wdata`, `lo_nib`} and hold_full <= 1.
  - If hold_full=1: the write is dropped, overrun <= 1, and hold is unchanged.
- Serialiser FSM states:
  - IDLE: `tx`=1. If hold_full, go to START, load shift <= hold, and clear hold_full.
  - START: `tx`=0 for `CLK_DIV` cycles, then go to DATA with bit index = 0.
  - DATA: `tx`=shift[0], LSB first, for `CLK_DIV` cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles. Then go to START if hold_full (back-to-back, no idle gap), else go to IDLE.
- busy = (state != IDLE).
- Baud counter: width $clog2(CLK_DIV), counts 0..CLK_DIV-1 and wraps. It resets to 0 on every state change.
- Simultaneous events:
  - A DATA_HI write in the same cycle the FSM takes the hold (IDLE→START or STOP→START): the FSM takes the old hold contents and the write fills hold. No overrun is raised.
  - A DATA_HI write to an empty hold in the same cycle is simply accepted.
  - Overrun set and STATUS write in the same cycle: the clear wins.
- `bus_we` with an address outside the window: no effect.
- Reset values, including reset mid-frame:
  - `tx`=1, state=IDLE, hold_full=0, overrun=0, `lo_nib`=0, shift=0, counter=0.
  - The frame in progress is abandoned; `tx` is high the cycle after reset.

## Timing
- Write accepted at the posedge where `bus_we`=1 and the address matches. The new status is visible on `bus_rdata` the following cycle.
- Read: `bus_rdata`/`bus_sel` are valid in the same cycle `bus_addr` is presented. The CPU samples them at the next edge, so no wait states are needed.
- Launch latency: DATA_HI written at edge N with the FSM in IDLE → hold_full=1 after N. The FSM enters START at N+1, so `tx` falls after edge N+1.
- Frame length: 10·`CLK_DIV` cycles. Back-to-back frames have no gap.
- The STATUS busy bit falls in the cycle after the last STOP cycle when hold is empty.

## Structure
- Shared package: `UART_OFS_DATA_LO`/`HI`/`STATUS` offset constants, the STATUS bit indices, and the FSM state enum (IDLE, START, DATA, STOP).
- One natural sub-module: `baud_tick`, a `CLK_DIV` counter with a synchronous restart input and a one-cycle `tick` output.
- Register decode and the holding register stay in the top module.
- Expected size is about 150–250 lines.

## Test plan
All scenarios use `CLK_DIV`=4.
- Reset check: assert `reset` 2 cycles → `tx`=1 and STATUS read = 4'b0000. After release, no `tx` activity for 100 cycles.
- Single byte: write +0=4'h5, then +1=4'hA (byte 8'hA5) → `tx` after launch is 0 ×4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 ×4. STATUS reads 4'b0010 mid-frame and 4'b0000 after.
- Back-to-back: write 8'h00, then 8'hFF while the first frame is in DATA → STATUS = 4'b0011. The second start bit follows the first stop bit with no idle cycle, for a total of 80 cycles.
- Overrun: with busy=1 and hold_full=1, write +1=4'h3 → STATUS = 4'b0111 and the held byte still transmits unchanged. Writing +2=4'h0 → overrun bit clears.
- Simultaneous take and write: issue a DATA_HI write on exactly the STOP→START edge with hold full → no overrun, and three frames emerge in order.
- Reset mid-frame: assert `reset` during DATA bit 3 → `tx`=1 the next cycle and STATUS=0. A fresh 8'h3C transmits correctly afterwards.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_mmio_pkg
//
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets inside the 4-address window
//   - bit positions of the fields in the STATUS nibble
//   - serialiser FSM state encoding
// ----------------------------------------------------------------------------
package uart_tx_mmio_pkg;

    // Register offsets (bus_addr[1:0] within the window)
    localparam logic [1:0] UART_OFS_DATA_LO = 2'd0;
    localparam logic [1:0] UART_OFS_DATA_HI = 2'd1;
    localparam logic [1:0] UART_OFS_STATUS  = 2'd2;

    // STATUS nibble layout: {0, overrun, busy, hold_full}
    localparam int UART_STAT_HOLD_FULL = 0;
    localparam int UART_STAT_BUSY      = 1;
    localparam int UART_STAT_OVERRUN   = 2;

    // Serialiser states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage : uart_tx_mmio_pkg

// File: rtl/uart_tx_mmio_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_tx_mmio_baud_tick
//
// Bit-period timer. Counts 0..CLK_DIV-1 and wraps; tick_o is high during the
// last cycle of each period. restart_i forces the counter back to 0 at the
// next edge so that every serialiser state begins a full bit period.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   restart_i  in   restart the period (counter -> 0 at next edge)
//   tick_o     out  one-cycle pulse in the final cycle of a period
// ----------------------------------------------------------------------------
module uart_tx_mmio_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    // Explicit wrap on tick: CLK_DIV need not be a power of two.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_tx_mmio_baud_tick

// File: rtl/uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped 8N1 UART transmitter on a 12-bit address / 4-bit data bus.
// Software writes a byte as two nibble stores (DATA_LO then DATA_HI) into a
// one-byte holding register; the serialiser drains the holding register and
// shifts the byte out LSB first at CLK_DIV clocks per bit.
//
// Register map (offset from BASE_ADDR):
//   +0 DATA_LO  W   low nibble staging register
//   +1 DATA_HI  W   completes the byte and launches it
//   +2 STATUS   R   {0, overrun, busy, hold_full}; any write clears overrun
//   +3 reserved     reads 0, writes ignored
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   bus_addr   in   [11:0] CPU address
//   bus_wdata  in   [3:0]  CPU write nibble
//   bus_we     in   write strobe
//   bus_rdata  out  [3:0]  read nibble (combinational)
//   bus_sel    out  address is inside this block's window
//   tx         out  serial line, idle high
// ----------------------------------------------------------------------------
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          CLK_DIV   = 16,
    parameter logic [11:0] BASE_ADDR = 12'hFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bus_addr,
    input  logic [3:0]  bus_wdata,
    input  logic        bus_we,
    output logic [3:0]  bus_rdata,
    output logic        bus_sel,
    output logic        tx
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [1:0] ofs;
    logic       wr_lo;
    logic       wr_hi;
    logic       wr_status;

    assign bus_sel   = (bus_addr[11:2] == BASE_ADDR[11:2]);
    assign ofs       = bus_addr[1:0];
    assign wr_lo     = bus_we && bus_sel && (ofs == UART_OFS_DATA_LO);
    assign wr_hi     = bus_we && bus_sel && (ofs == UART_OFS_DATA_HI);
    assign wr_status = bus_we && bus_sel && (ofs == UART_OFS_STATUS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        overrun_q, overrun_d;
    logic [3:0]  lo_nib_q, lo_nib_d;

    logic        take;      // FSM moves the holding register into the shifter
    logic        busy;
    logic        restart;
    logic        tick;

    assign busy    = (state_q != ST_IDLE);
    assign restart = (state_d != state_q);

    uart_tx_mmio_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart),
        .tick_o    (tick)
    );

    // ------------------------------------------------------------------
    // Serialiser FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        take      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_START;
                    shift_d = hold_q;
                    take    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    // A pending byte starts immediately: no idle gap.
                    if (hold_full_q) begin
                        state_d = ST_START;
                        shift_d = hold_q;
                        take    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serial output decoded from the current state.
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register, staging nibble and overrun flag
    // ------------------------------------------------------------------
    always_comb begin
        lo_nib_d    = lo_nib_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;

        if (wr_lo) begin
            lo_nib_d = bus_wdata;
        end

        if (take) begin
            hold_full_d = 1'b0;
        end

        // When the FSM empties the hold in this same cycle, the slot is
        // free for the incoming byte and no overrun is flagged.
        if (wr_hi) begin
            if (!hold_full_q || take) begin
                hold_d      = {bus_wdata, lo_nib_q};
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Clear has priority over set.
        if (wr_status) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            bit_idx_q   <= 3'd0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            lo_nib_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            lo_nib_q    <= lo_nib_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux: only STATUS returns data
    // ------------------------------------------------------------------
    always_comb begin
        bus_rdata = 4'h0;
        if (bus_sel && (ofs == UART_OFS_STATUS)) begin
            bus_rdata[UART_STAT_HOLD_FULL] = hold_full_q;
            bus_rdata[UART_STAT_BUSY]      = busy;
            bus_rdata[UART_STAT_OVERRUN]   = overrun_q;
        end
    end

endmodule : uart_tx_mmio

// File: tb/tb_uart_tx_mmio.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_mmio
//
// Directed bench for uart_tx_mmio with CLK_DIV=4. Inputs change 1 ns after a
// rising edge; tx is recorded on falling edges into tx_log while capture is
// enabled and compared against exp_q, built from hand-specified bytes.
// ----------------------------------------------------------------------------
module tb_uart_tx_mmio;

  localparam int          CLK_DIV = 4;
  localparam logic [11:0] A_LO    = 12'hFF0;
  localparam logic [11:0] A_HI    = 12'hFF1;
  localparam logic [11:0] A_ST    = 12'hFF2;
  localparam logic [11:0] A_RSV   = 12'hFF3;
  localparam logic [11:0] A_NONE  = 12'h000;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [11:0] bus_addr;
  logic [3:0]  bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_rdata;
  logic        bus_sel;
  logic        tx;

  uart_tx_mmio #(
    .CLK_DIV   (CLK_DIV),
    .BASE_ADDR (12'hFF0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .bus_sel   (bus_sel),
    .tx        (tx)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [0:0] exp_q[$];
  logic [0:0] tx_log[$];
  logic       cap_en = 1'b0;

  always @(negedge clk) begin
    if (cap_en) tx_log.push_back(tx);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic bus_write(input logic [11:0] addr, input logic [3:0] data);
    @(posedge clk); #1;
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    @(posedge clk); #1;
    bus_we    = 1'b0;
    bus_addr  = A_NONE;
    bus_wdata = 4'h0;
  endtask

  task automatic read_reg(input logic [11:0] addr, output logic [3:0] data, output logic sel);
    bus_addr = addr;
    #1;
    data = bus_rdata;
    sel  = bus_sel;
    bus_addr = A_NONE;
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp);
    logic [3:0] d;
    logic       s;
    read_reg(A_ST, d, s);
    check_eq(tag, d, exp);
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus_write(A_LO, b[3:0]);
    bus_write(A_HI, b[7:4]);
  endtask

  task automatic push_bit(input logic v);
    for (int j = 0; j < CLK_DIV; j++) exp_q.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] b);
    push_bit(1'b0);
    for (int k = 0; k < 8; k++) push_bit(b[k]);
    push_bit(1'b1);
  endtask

  task automatic push_idle(input int n);
    for (int j = 0; j < n; j++) exp_q.push_back(1'b1);
  endtask

  // Call right after the launching DATA_HI write returns: the first sample
  // then lands in the first START cycle.
  task automatic start_capture();
    @(posedge clk); #1;
    cap_en = 1'b1;
  endtask

  task automatic check_log(input string tag);
    int budget = 0;
    int n;
    while (tx_log.size() < exp_q.size() && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    #1;
    cap_en = 1'b0;
    check_eq({tag, "_len"}, tx_log.size(), exp_q.size());
    n = (tx_log.size() < exp_q.size()) ? tx_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s[%0d]", tag, i), tx_log[i], exp_q[i]);
    end
    tx_log.delete();
    exp_q.delete();
  endtask

  task automatic wait_until_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [3:0] d;
    logic       s;
    int         c_launch;

    reset     = 1'b1;
    bus_addr  = A_NONE;
    bus_wdata = 4'h0;
    bus_we    = 1'b0;

    // ---- Reset check and decode ----
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx", tx, 1'b1);
    check_status("rst_status", 4'b0000);
    reset = 1'b0;

    read_reg(A_RSV, d, s);
    check_eq("rsv_rdata", d, 4'h0);
    check_eq("rsv_sel", s, 1'b1);
    read_reg(A_HI, d, s);
    check_eq("hi_rdata", d, 4'h0);
    read_reg(A_LO, d, s);
    check_eq("lo_rdata", d, 4'h0);
    read_reg(12'hFEF, d, s);
    check_eq("below_sel", s, 1'b0);
    read_reg(12'hFF4, d, s);
    check_eq("above_sel", s, 1'b0);
    read_reg(12'h7F2, d, s);
    check_eq("alias_sel", s, 1'b0);
    check_eq("alias_rdata", d, 4'h0);

    // Writes outside the window or to the reserved slot do nothing.
    bus_write(12'hFE1, 4'hA);
    bus_write(12'h7F1, 4'h5);
    bus_write(A_RSV, 4'hF);
    check_status("ignored_wr_status", 4'b0000);
    cap_en = 1'b1;
    push_idle(100);
    check_log("idle");

    // ---- Single byte 8'hA5 ----
    write_byte(8'hA5);
    check_status("launch_status", 4'b0001);
    start_capture();
    push_frame(8'hA5);
    push_idle(8);
    repeat (20) @(posedge clk);
    #1;
    check_status("mid_frame_status", 4'b0010);
    check_log("frame_a5");
    check_status("after_a5_status", 4'b0000);

    // ---- Back-to-back 8'h00 then 8'hFF ----
    write_byte(8'h00);
    start_capture();
    push_frame(8'h00);
    push_frame(8'hFF);
    push_idle(8);
    repeat (8) @(posedge clk);
    #1;
    write_byte(8'hFF);
    check_status("b2b_status", 4'b0011);
    check_log("b2b");
    check_status("after_b2b_status", 4'b0000);

    // ---- Overrun: 8'h12 in flight, 8'h56 held, DATA_HI=3 dropped ----
    write_byte(8'h12);
    start_capture();
    push_frame(8'h12);
    push_frame(8'h56);
    push_idle(8);
    write_byte(8'h56);
    check_status("held_status", 4'b0011);
    bus_write(A_HI, 4'h3);
    check_status("overrun_status", 4'b0111);
    bus_write(A_ST, 4'h0);
    check_status("overrun_clr_status", 4'b0011);
    check_log("overrun");
    check_status("after_overrun_status", 4'b0000);

    // ---- DATA_HI write on the STOP->START edge with hold full ----
    write_byte(8'h81);
    c_launch = cyc;
    start_capture();
    push_frame(8'h81);
    push_frame(8'h42);
    push_frame(8'hC7);
    push_idle(8);
    write_byte(8'h42);
    bus_write(A_LO, 4'h7);
    // Launch edge + 1 (enter START) + 40 cycles of frame = take edge.
    wait_until_cyc(c_launch + 39);
    bus_write(A_HI, 4'hC);
    check_status("simul_status", 4'b0011);
    check_log("simul");
    check_status("after_simul_status", 4'b0000);

    // ---- Reset during DATA bit 3 of 8'h06 ----
    write_byte(8'h06);
    c_launch = cyc;
    // START at +1, DATA at +5, bit 3 spans edges +17..+21.
    wait_until_cyc(c_launch + 18);
    check_eq("pre_reset_tx", tx, 1'b0);
    check_status("pre_reset_status", 4'b0010);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_reset_tx", tx, 1'b1);
    check_status("mid_reset_status", 4'b0000);
    reset = 1'b0;

    // Staging nibble was cleared by reset: DATA_HI alone gives 8'h30.
    bus_write(A_HI, 4'h3);
    check_status("post_reset_launch", 4'b0001);
    start_capture();
    push_frame(8'h30);
    push_idle(4);
    check_log("post_reset_30");

    write_byte(8'h3C);
    start_capture();
    push_frame(8'h3C);
    push_idle(8);
    check_log("post_reset_3c");
    check_status("final_status", 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_uart_tx_mmio
